// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: default datapath widths and the
// MEM/WB skid buffer state encoding (the encoding doubles as the occupancy count).
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_LANES  = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_lane_mask.sv
// Capture-side lane cleanup: disabled lanes become all-zero, and when two enabled
// lanes target the same register the higher lane wins.
module wb_lane_mask
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic [LANES*ADDR_W-1:0] wd_i,
    input  logic [LANES-1:0]        wreg_i,
    input  logic [LANES*DATA_W-1:0] wdata_i,
    output logic [LANES*ADDR_W-1:0] wd_o,
    output logic [LANES-1:0]        wreg_o,
    output logic [LANES*DATA_W-1:0] wdata_o
);

    logic keep;

    always_comb begin
        wd_o    = '0;
        wreg_o  = '0;
        wdata_o = '0;
        keep    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            keep = wreg_i[i];
            // A later lane writing the same register shadows this one.
            for (int j = i + 1; j < LANES; j++) begin
                if (wreg_i[j] && (wd_i[j*ADDR_W +: ADDR_W] == wd_i[i*ADDR_W +: ADDR_W])) begin
                    keep = 1'b0;
                end
            end
            if (keep) begin
                wreg_o[i]                   = 1'b1;
                wd_o[i*ADDR_W +: ADDR_W]    = wd_i[i*ADDR_W +: ADDR_W];
                wdata_o[i*DATA_W +: DATA_W] = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// Two-entry MEM->WB skid buffer: main register drives the WB side, skid register
// absorbs one extra entry so in_ready can be a pure register.
module mem_wb_skid
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ADDR_W-1:0] in_wd,
    input  logic [LANES-1:0]        in_wreg,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ADDR_W-1:0] out_wd,
    output logic [LANES-1:0]        out_wreg,
    output logic [LANES*DATA_W-1:0] out_wdata,
    output logic [1:0]              occ
);

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [LANES*DATA_W-1:0] wdata;
    } entry_t;

    wb_state_e               state_q;
    logic                    in_ready_q;
    entry_t                  main_q;
    entry_t                  skid_q;
    entry_t                  cap_d;
    logic [LANES*ADDR_W-1:0] cap_wd_d;
    logic [LANES-1:0]        cap_wreg_d;
    logic [LANES*DATA_W-1:0] cap_wdata_d;
    logic                    in_fire;
    logic                    out_fire;

    wb_lane_mask #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_lane_mask (
        .wd_i    (in_wd),
        .wreg_i  (in_wreg),
        .wdata_i (in_wdata),
        .wd_o    (cap_wd_d),
        .wreg_o  (cap_wreg_d),
        .wdata_o (cap_wdata_d)
    );

    assign cap_d    = {cap_wd_d, cap_wreg_d, cap_wdata_d};
    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid && out_ready;

    // main_q is kept all-zero whenever the buffer is empty, so bubbles drive zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q  <= cap_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= cap_d;
                    end else if (in_fire) begin
                        skid_q     <= cap_d;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        main_q  <= '0;
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        skid_q     <= '0;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                    main_q     <= '0;
                    skid_q     <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_wd    = main_q.wd;
    assign out_wreg  = main_q.wreg;
    assign out_wdata = main_q.wdata;
    assign occ       = state_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid with two lanes: directed scenarios plus a randomized
// backpressure run, all checked through an expected-entry queue.
module tb_mem_wb_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 2;
    localparam int EW = LN*AW + LN + LN*DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [LN*AW-1:0] in_wd;
    logic [LN-1:0]    in_wreg;
    logic [LN*DW-1:0] in_wdata;
    logic             out_valid;
    logic             out_ready;
    logic [LN*AW-1:0] out_wd;
    logic [LN-1:0]    out_wreg;
    logic [LN*DW-1:0] out_wdata;
    logic [1:0]       occ;

    logic fix_ready;
    logic rnd_ready = 1'b0;
    logic rand_bp;
    assign out_ready = rand_bp ? rnd_ready : fix_ready;

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] prev_out = '0;
    logic          prev_hold = 1'b0;
    logic [EW-1:0] cur_out;
    assign cur_out = {out_wd, out_wreg, out_wdata};

    mem_wb_skid #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .LANES  (LN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wreg   (in_wreg),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wd    (out_wd),
        .out_wreg  (out_wreg),
        .out_wdata (out_wdata),
        .occ       (occ)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference capture: zero disabled lanes; equal targets -> lane 1 wins.
    function automatic logic [EW-1:0] model(input logic [LN*AW-1:0] wd, input logic [LN-1:0] wreg,
                                            input logic [LN*DW-1:0] wdata);
        logic [LN*AW-1:0] m_wd;
        logic [LN-1:0]    m_wreg;
        logic [LN*DW-1:0] m_wdata;
        m_wreg = wreg;
        if (wreg == 2'b11 && wd[4:0] == wd[9:5]) m_wreg[0] = 1'b0;
        m_wd    = wd;
        m_wdata = wdata;
        if (!m_wreg[0]) begin m_wd[4:0] = '0; m_wdata[31:0] = '0; end
        if (!m_wreg[1]) begin m_wd[9:5] = '0; m_wdata[63:32] = '0; end
        return {m_wd, m_wreg, m_wdata};
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && out_valid) check_val("hold_stable", 128'(cur_out), 128'(prev_out));
            if (!out_valid) check_val("bubble_zero", 128'(cur_out), 128'd0);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    check_val("sb_avail", 128'(exp_q.size() != 0), 128'd1);
                    if (exp_q.size() != 0) check_val("sb_data", 128'(cur_out), 128'(exp_q.pop_front()));
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_wd, in_wreg, in_wdata));
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_out  = cur_out;
        end
    end

    // driver tasks
    task automatic drive(input logic [LN*AW-1:0] wd, input logic [LN-1:0] wreg, input logic [LN*DW-1:0] wdata);
        int guard = 0;
        in_valid = 1'b1;
        in_wd    = wd;
        in_wreg  = wreg;
        in_wdata = wdata;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("drive_accept", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_wd    = LN*AW'($urandom);
        in_wreg  = LN'($urandom);
        in_wdata = {$urandom, $urandom};
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; fix_ready = 1'b0; rand_bp = 1'b0;
        in_wd = '0; in_wreg = '0; in_wdata = '0;
        #1;
        check_val("rst_occ", 128'(occ), 128'd0);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_in_ready", 128'(in_ready), 128'd1);
        check_val("rst_out", 128'(cur_out), 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // streaming: one entry per cycle, latency 1
        fix_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive({5'($urandom), 5'(i)}, 2'b01, {$urandom, $urandom});
            check_val("tp_out_valid", 128'(out_valid), 128'd1);
            check_val("tp_out_wd0", 128'(out_wd[4:0]), 128'(i));
            check_val("tp_occ", 128'(occ), 128'd1);
            check_val("tp_in_ready", 128'(in_ready), 128'd1);
        end
        idle(2);
        check_val("tp_drained_occ", 128'(occ), 128'd0);

        // backpressure
        fix_ready = 1'b0;
        drive({5'd0, 5'd3}, 2'b01, {32'h0, 32'h3333_0003});
        drive({5'd0, 5'd4}, 2'b01, {32'h0, 32'h4444_0004});
        idle(1);
        check_val("bp_occ", 128'(occ), 128'd2);
        check_val("bp_in_ready", 128'(in_ready), 128'd0);
        check_val("bp_out_wd", 128'(out_wd[4:0]), 128'd3);
        fix_ready = 1'b1;
        idle(1);
        check_val("bp_second_wd", 128'(out_wd[4:0]), 128'd4);
        check_val("bp_second_occ", 128'(occ), 128'd1);
        idle(2);
        check_val("bubble_valid", 128'(out_valid), 128'd0);
        check_val("bubble_wd", 128'(out_wd), 128'd0);
        check_val("bubble_wreg", 128'(out_wreg), 128'd0);
        check_val("bubble_wdata", 128'(out_wdata), 128'd0);

        // flush while full, and while one entry is held with input accepted
        fix_ready = 1'b0;
        drive({5'd0, 5'd6}, 2'b01, {32'h0, 32'h6});
        drive({5'd0, 5'd7}, 2'b01, {32'h0, 32'h7});
        check_val("fl_occ_full", 128'(occ), 128'd2);
        flush = 1'b1; in_valid = 1'b1; in_wd = {5'd0, 5'd9}; in_wreg = 2'b01; in_wdata = {32'h0, 32'h9};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_val("fl_occ", 128'(occ), 128'd0);
        check_val("fl_out_valid", 128'(out_valid), 128'd0);
        check_val("fl_in_ready", 128'(in_ready), 128'd1);
        drive({5'd0, 5'd10}, 2'b01, {32'h0, 32'hA});
        flush = 1'b1; in_valid = 1'b1; in_wd = {5'd0, 5'd11}; in_wreg = 2'b01; in_wdata = {32'h0, 32'hB};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_val("fl2_occ", 128'(occ), 128'd0);
        fix_ready = 1'b1;
        idle(4);
        check_val("fl_no_ghost", 128'(out_valid), 128'd0);

        // lane priority
        drive({5'd5, 5'd5}, 2'b11, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
        check_val("lane_wreg", 128'(out_wreg), 128'b10);
        check_val("lane1_data", 128'(out_wdata[63:32]), 128'hBBBB_BBBB);
        check_val("lane0_data", 128'(out_wdata[31:0]), 128'd0);
        check_val("lane0_wd", 128'(out_wd[4:0]), 128'd0);
        check_val("lane1_wd", 128'(out_wd[9:5]), 128'd5);
        idle(2);

        // random traffic with random backpressure and collisions
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive({5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        fix_ready = 1'b1;
        idle(5);
        check_val("rnd_drained", 128'(exp_q.size()), 128'd0);

        // asynchronous reset mid-cycle while full
        fix_ready = 1'b0;
        drive({5'd0, 5'd1}, 2'b01, {32'h0, 32'h1});
        drive({5'd0, 5'd2}, 2'b01, {32'h0, 32'h2});
        in_valid = 1'b0;
        check_val("ar_occ_full", 128'(occ), 128'd2);
        #1 rst = 1'b1;
        #1;
        check_val("ar_out_valid", 128'(out_valid), 128'd0);
        check_val("ar_occ", 128'(occ), 128'd0);
        check_val("ar_in_ready", 128'(in_ready), 128'd1);
        check_val("ar_out", 128'(cur_out), 128'd0);
        exp_q.delete();
        #1 rst = 1'b0;
        fix_ready = 1'b1;
        drive({5'd0, 5'd12}, 2'b01, {32'h0, 32'hC});
        check_val("ar_first_occ", 128'(occ), 128'd1);
        check_val("ar_first_wd", 128'(out_wd[4:0]), 128'd12);
        idle(3);

        check_val("final_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid.md
MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the width of one write-back data word.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning the width of a destination register index.
REQ-003 The module SHALL have parameter LANES, default 1 (legal range 1..4), meaning the number of parallel write-back lanes.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port flush, input, 1 bit: discards all held entries.
REQ-007 The module SHALL have port in_valid, input, 1 bit: the MEM-side entry is valid.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block can accept an entry.
REQ-009 The module SHALL have port in_wd, input, LANES*ADDR_W bits: per-lane destination index; lane 0 occupies the LSBs.
REQ-010 The module SHALL have port in_wreg, input, LANES bits: per-lane write enable.
REQ-011 The module SHALL have port in_wdata, input, LANES*DATA_W bits: per-lane write data.
REQ-012 The module SHALL have port out_valid, output, 1 bit: the WB-side entry is valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit: WB consumes the entry.
REQ-014 The module SHALL have ports out_wd, out_wreg and out_wdata, outputs, with widths mirroring the in_* ports: the presented entry.
REQ-015 The module SHALL have port occ, output, 2 bits: the number of entries held (0..2).

Function
REQ-016 The block SHALL be a two-entry skid buffer made of a main register (which drives out_*) and a skid register, with states EMPTY, ONE and FULL.
REQ-017 A transfer SHALL occur on any edge where valid and ready are both high on the same side.
REQ-018 in_ready SHALL be a registered signal, equal to 1 in states EMPTY and ONE and 0 in state FULL.
REQ-019 State EMPTY SHALL move to ONE on an input transfer, with the entry loaded into main; the latency from input to out_valid is 1 cycle.
REQ-020 In state ONE, an input transfer together with an output transfer SHALL load main and stay in ONE.
REQ-021 In state ONE, an input transfer without an output transfer SHALL load skid and move to FULL.
REQ-022 In state ONE, an output transfer without an input transfer SHALL move to EMPTY.
REQ-023 In state FULL, an output transfer SHALL move skid into main and move to ONE; no input is accepted in FULL.
REQ-024 Entries SHALL leave the block in acceptance order, with none lost or duplicated.
REQ-025 When out_valid is 0, out_wd, out_wreg and out_wdata SHALL all be zero, so a bubble never writes the register file.
REQ-026 When out_valid is 1 and out_ready is 0, out_* SHALL hold stable.
REQ-027 For any lane i where in_wreg[i] is 0, that lane's wd and wdata SHALL be captured as zero.
REQ-028 If two lanes in one entry have wreg set with equal wd, the higher lane index SHALL win: the lower lane's wreg is cleared at capture.
REQ-029 On a flush edge, the block SHALL move to EMPTY with in_ready set to 1; an input transfer on the same edge is discarded; flush overrides every transition.
REQ-030 occ SHALL equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-031 Asserting rst SHALL immediately force EMPTY, out_valid=0, all out_* zero, in_ready=1 and occ=0, including in the middle of a transfer.
REQ-032 After rst is released, the first input transfer SHALL be accepted on the first clk edge.

Structure
REQ-033 State encodings and the default widths SHALL live in the shared package cpu_pkg.
REQ-034 Per-lane capture masking (REQ-027 and REQ-028) SHALL be one sub-module, wb_lane_mask, instantiated once per input entry.

Verification
REQ-035 Reset check: assert rst mid-cycle while in FULL -> out_valid=0, occ=0 and in_ready=1 immediately, before the next edge.
REQ-036 Throughput check: stream entries wd=1..8, in_valid=1 and out_ready=1 -> one entry per cycle, in order, first at latency 1, occ stays 1.
REQ-037 Backpressure check: out_ready=0 for 3 cycles while sending wd=3 and wd=4 -> occ=2, in_ready=0, out_wd=3 held; release -> 3 then 4 are delivered.
REQ-038 Flush check: occ=2, then flush together with in_valid (wd=9) -> next cycle occ=0, out_valid=0, and wd=9 never appears.
REQ-039 Lane check (LANES=2): lane0 wd=5 and lane1 wd=5, both wreg=1, data A/B -> out_wreg=2'b10, out_wdata lane1=B, lane0=0.
REQ-040 Bubble check: an idle cycle after a drain -> out_wd=0, out_wreg=0, out_wdata=0.
